// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU front-end definitions: address/instruction widths, the PC
// increment, and the fetch-entry record stored in the fetch queue.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    // One queued fetch: the address it came from and the word returned.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instruction;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock circular-buffer FIFO with a synchronous clear. The head entry
// is presented combinationally and reads as zero while empty.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (pointers and count to 0)
//   clear_i  in   synchronous flush; wins over push_i/pop_i in the same cycle
//   push_i   in   write din_i at the tail (ignored when full)
//   din_i    in   WIDTH-bit write data
//   pop_i    in   advance the head (ignored when empty)
//   dout_o   out  head entry, zero when empty
//   count_o  out  occupancy, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty;
    logic full;
    logic push_ok;
    logic pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push_i && !full && !clear_i;
    assign pop_ok  = pop_i && !empty && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale words are never visible because the
    // output is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch unit with a small prefetch queue. Owns the fetch PC,
// issues requests to instruction memory while the queue has room, and
// presents the oldest fetched {pc, instruction} to the IF/ID register.
// A taken branch flushes the queue and redirects the fetch PC.
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   synchronous active-high reset
//   imem_addr        out  current fetch address
//   imem_req         out  fetch request for imem_addr
//   imem_ready       in   imem_data is valid for imem_addr this cycle
//   imem_data        in   fetched instruction word
//   branch_taken     in   MEM-stage redirect
//   branch_target    in   redirect address (low two bits dropped)
//   deq_ready        in   IF/ID accepts the head entry this cycle
//   out_valid        out  head entry valid
//   out_pc           out  head entry PC (0 when empty)
//   out_instruction  out  head entry instruction (0 when empty)
//   count            out  queue occupancy
//   flush_count      out  only with FETCH_QUEUE_STATS_EN: saturating count
//                         of redirects that discarded at least one entry
//
// Handshakes: a fetch completes on a cycle where imem_req && imem_ready;
// an entry leaves on a cycle where out_valid && deq_ready. Neither side may
// make its completion depend on the other's in the same cycle, and a
// redirect cancels both.
//
// Optional feature macro: FETCH_QUEUE_STATS_EN.
// -----------------------------------------------------------------------------
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic                   imem_req,
    input  logic                   imem_ready,
    input  logic [INSTR_W-1:0]     imem_data,
    input  logic                   branch_taken,
    input  logic [ADDR_W-1:0]      branch_target,
    input  logic                   deq_ready,
    output logic                   out_valid,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [INSTR_W-1:0]     out_instruction,
    output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]            flush_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              full;
    logic              push;
    logic              pop;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head_entry;
    logic [CNT_W-1:0]  fifo_count;

    // Request only with a free slot available now: a pop in the same cycle
    // does not open a slot for this cycle's fetch.
    assign full     = (fifo_count == CNT_W'(DEPTH));
    assign imem_req = !full && !branch_taken;
    assign push     = imem_req && imem_ready;
    assign pop      = out_valid && deq_ready && !branch_taken;

    assign wr_entry = '{pc: pc_q, instruction: imem_data};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (branch_taken),
        .push_i  (push),
        .din_i   (wr_entry),
        .pop_i   (pop),
        .dout_o  (head_entry),
        .count_o (fifo_count)
    );

    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = {branch_target[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_addr       = pc_q;
    assign count           = fifo_count;
    assign out_valid       = (fifo_count != '0);
    assign out_pc          = head_entry.pc;
    assign out_instruction = head_entry.instruction;

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        flush_count_d = flush_count_q;
        if (branch_taken && out_valid && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_count_q <= '0;
        end else begin
            flush_count_q <= flush_count_d;
        end
    end

    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed scenarios followed by random traffic, all checked against a
// queue-based reference model of the fetch queue.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [63:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        deq_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instruction;
  logic [$clog2(DEPTH):0] count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] flush_count;
`endif

  logic [31:0] junk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {a[17:2], a[17:2] ^ 16'hBEEF};
  endfunction

  // Memory responder: returns the word for the requested address, junk
  // otherwise so an unrequested capture would be visible.
  assign imem_data = imem_req ? instr_of(imem_addr) : junk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_ready      (imem_ready),
    .imem_data       (imem_data),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .deq_ready       (deq_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .count           (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .flush_count     (flush_count)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  logic [95:0] exp_q[$];   // {pc, instruction}, oldest first
  logic [63:0] mdl_pc;
  logic [31:0] mdl_flush;
  int tests;
  int fails;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_pc    = RESET_PC;
    mdl_flush = '0;
  endtask

  // One clock edge of the fetch queue as described by its rules.
  task automatic model_step(input logic rst, input logic br, input logic [63:0] tgt,
                            input logic rdy, input logic deq);
    logic do_req;
    if (rst) begin
      model_reset();
    end else if (br) begin
      if (exp_q.size() > 0 && mdl_flush != 32'hFFFF_FFFF) mdl_flush++;
      exp_q.delete();
      mdl_pc = tgt & ~64'h3;
    end else begin
      do_req = (exp_q.size() < DEPTH);
      if (exp_q.size() > 0 && deq) void'(exp_q.pop_front());
      if (do_req && rdy) begin
        exp_q.push_back({mdl_pc, instr_of(mdl_pc)});
        mdl_pc = mdl_pc + 64'd4;
      end
    end
  endtask

  task automatic check_outputs();
    logic [95:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 96'h0;
    chk("imem_req", imem_req, (exp_q.size() < DEPTH) && !branch_taken);
    chk("imem_addr", imem_addr, mdl_pc);
    chk("count", count, exp_q.size());
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("out_pc", out_pc, head[95:32]);
    chk("out_instruction", out_instruction, head[31:0]);
`ifdef FETCH_QUEUE_STATS_EN
    chk("flush_count", flush_count, mdl_flush);
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; leaves inputs applied and returns at the
  // next falling edge.
  task automatic cycle(input logic rst, input logic br, input logic [63:0] tgt,
                       input logic rdy, input logic deq);
    reset         = rst;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    deq_ready     = deq;
    junk          = $urandom();
    #1;
    check_outputs();
    model_step(rst, br, tgt, rdy, deq);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    reset         = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_ready    = 1'b0;
    deq_ready     = 1'b0;
    junk          = '0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    #1;

    // reset state
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instruction", out_instruction, 0);
    chk("rst_imem_addr", imem_addr, RESET_PC);

    // streaming: one word in and one out every cycle
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
      chk("stream_pc", out_pc, 64'(k * 4));
      chk("stream_count", count, 1);
    end

    // fill to capacity with no dequeue
    cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("fill_count", count, 4);
    chk("fill_req", imem_req, 0);
    chk("fill_addr", imem_addr, 64'd16);

    // full plus pop: no fetch that cycle, fetch resumes next cycle
    cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("full_pop_count", count, 3);
    chk("full_pop_req", imem_req, 1);
    chk("full_pop_addr", imem_addr, 64'd16);
    cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("refill_count", count, 4);
    chk("refill_addr", imem_addr, 64'd20);

    // redirect with entries pending
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("pre_br_count", count, 3);
    cycle(1'b0, 1'b1, 64'h103, 1'b1, 1'b1);
    chk("br_count", count, 0);
    chk("br_out_valid", out_valid, 0);
    chk("br_addr", imem_addr, 64'h100);
`ifdef FETCH_QUEUE_STATS_EN
    chk("br_flush_count", flush_count, 1);
`endif

    // memory stalls: words at 0 and 4 only, no gaps or repeats
    cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("stall_instr0", out_instruction, instr_of(64'h0));
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("stall_gap_valid", out_valid, 0);
    chk("stall_gap_addr", imem_addr, 64'd4);
    cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("stall_instr4", out_instruction, instr_of(64'h4));
    chk("stall_count", count, 1);
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("stall_drain", count, 0);

    // reset beats a same-cycle redirect
    cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("pre_rst_count", count, 2);
    cycle(1'b1, 1'b1, 64'h200, 1'b1, 1'b0);
    chk("rst_br_count", count, 0);
    chk("rst_br_addr", imem_addr, RESET_PC);

    // random traffic; dequeue probability changes in phases so the queue
    // spends time both full and empty
    for (int i = 0; i < 600; i++) begin
      logic r_rst, r_br, r_rdy, r_deq;
      logic [63:0] r_tgt;
      r_rst = ($urandom_range(63) == 0);
      r_br  = ($urandom_range(15) == 0);
      r_tgt = {$urandom(), $urandom()};
      r_rdy = ($urandom_range(3) != 0);
      r_deq = ($urandom_range(3) < ((i >> 6) & 3));
      cycle(r_rst, r_br, r_tgt, r_rdy, r_deq);
    end
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue capacity in instructions; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_PC, default 64'h0, fetch address loaded on reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  64  current fetch address to instruction memory.
REQ-006 imem_req  output  1  fetch request for imem_addr.
REQ-007 imem_ready  input  1  instruction memory returns imem_data for imem_addr this cycle.
REQ-008 imem_data  input  32  fetched instruction word.
REQ-009 branch_taken  input  1  redirect from the MEM-stage branch decision (Branch & ALUZero).
REQ-010 branch_target  input  64  redirect address (MEM-stage jump address).
REQ-011 deq_ready  input  1  IF/ID pipeline register accepts an entry this cycle.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_pc  output  64  PC of head entry.
REQ-014 out_instruction  output  32  instruction of head entry.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 imem_req SHALL be 1 when count < DEPTH and branch_taken is 0, else 0.
REQ-017 Push SHALL occur when imem_req & imem_ready: {imem_addr, imem_data} written at tail; fetch PC SHALL advance by 4 (modulo 2^64).
REQ-018 Pop SHALL occur when out_valid & deq_ready; head advances by one.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; push-only +1, pop-only -1.
REQ-020 Head/tail pointers SHALL wrap modulo DEPTH.
REQ-021 out_valid SHALL equal (count != 0); out_pc/out_instruction SHALL be combinational from head, and SHALL be 0 when empty.
REQ-022 Latency: a word pushed at edge N SHALL be visible at the outputs after edge N when the queue was empty.
REQ-023 branch_taken SHALL have priority: at that edge queue cleared (count 0), any pop/push ignored, fetch PC loaded with branch_target with bits [1:0] forced to 0.
REQ-024 When full, no fetch SHALL be issued even if a pop occurs the same cycle (no full-bypass).
REQ-025 imem_data SHALL be ignored when imem_req is 0.

Reset
REQ-026 On reset: fetch PC = RESET_PC, count = 0, pointers = 0, out_valid = 0, out_pc = 0, out_instruction = 0.
REQ-027 Reset SHALL override branch_taken, push and pop in the same cycle; in-flight entries are discarded.

Configuration
REQ-028 Macro FETCH_QUEUE_STATS_EN: when defined, output flush_count (32 bits) SHALL count branch_taken flushes that discarded count > 0 entries, saturating at 32'hFFFFFFFF, cleared by reset.
REQ-029 Without FETCH_QUEUE_STATS_EN the port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package cpu_pkg SHALL hold ADDR_W (64), INSTR_W (32), PC_STEP (4) and the fetch-entry struct {pc, instruction}.
REQ-031 Storage SHALL be one sub-module sync_fifo (parameterised width/depth, with synchronous clear) instantiated once; fetch-PC and redirect logic stay in fetch_queue.

Verification
REQ-032 Reset with RESET_PC=0, imem_ready=1, deq_ready=1 -> out_pc 0,4,8,12 on consecutive cycles, count steady at 1.
REQ-033 deq_ready=0, imem_ready=1, DEPTH=4 -> count reaches 4 after 4 edges, imem_req drops to 0, imem_addr holds 16.
REQ-034 Full queue, deq_ready=1 one cycle -> count 3, next cycle imem_req=1 and push at addr 16.
REQ-035 count=3, branch_taken=1, target 64'h103 -> next cycle count 0, out_valid 0, imem_addr 64'h100; flush_count increments to 1 when STATS enabled.
REQ-036 imem_ready toggling 1,0,1 with deq_ready=1 -> out_instruction sequence matches memory words at 0 and 4 only, no duplicates, no gaps.
REQ-037 Reset asserted while count=2 and branch_taken=1 -> next cycle count 0, imem_addr RESET_PC.
